riscv_fetch_decode_execute: RTL and testbench
=============================================

RISCV_FETCH_DECODE_EXECUTE -- requirements
Module: riscv_fetch_decode_execute

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 32, number of 32-bit instruction-memory words.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are named as elsewhere in the codebase (clk, rst).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 estado  in  4  datapath phase: IF=0000, ID=0001, EX=0010; all other codes mean hold.
REQ-006 PC  in  32  byte address of the instruction to fetch.
REQ-007 readdata1R, readdata2R  in  32 each  rs1 and rs2 operand values.
REQ-008 imem_we  in  1; imem_addr  in  5; imem_wdata  in  32  synchronous instruction-memory write port.
REQ-009 instrucao  out  32  fetched instruction.
REQ-010 opcode  out  7; rd, rs1, rs2  out  5 each; funct3  out  3; funct7  out  7  decoded fields.
REQ-011 immediate  out  32  sign-extended immediate; negativo  out  1  immediate sign.
REQ-012 tipo  out  3  class: 0=R, 1=load, 2=I-arith, 3=store, 4=branch, 7=unsupported.
REQ-013 aluresult2  out  32  ALU result; aluresult1  out  1  zero flag (aluresult2==0); pcsrc  out  1  branch taken.

Function
REQ-014 imem_we=1 SHALL write imem_wdata to imem[imem_addr] at the rising edge, regardless of estado.
REQ-015 estado==IF at the edge: instrucao <= imem[PC[31:2]]; index >= IMEM_DEPTH yields 0; simultaneous write to the same word returns the old data.
REQ-016 estado==ID at the edge: latch opcode=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
REQ-017 tipo decode: 0110011->0, 0000011->1, 0010011->2, 0100011->3, 1100011->4, else 7.
REQ-018 immediate: I/load {sext instr[31:20]}; store {sext instr[31:25],instr[11:7]}; branch {sext instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; R/unsupported 0.
REQ-019 negativo = immediate[31].
REQ-020 estado==EX at the edge: compute with A=readdata1R, B=readdata2R, using the decoded fields latched at ID.
REQ-021 R funct3=000: funct7=0100000 -> A-B; funct7=0000000 -> A+B.
REQ-022 R funct3=100, funct7=0 -> A^B; R funct3=101, funct7=0 -> A>>B[4:0] (logical shift).
REQ-023 I-arith funct3=000 (addi), load (lw), store (sw) -> A+immediate.
REQ-024 branch funct3=000 (beq) -> A-B; pcsrc=1 iff A==B; every other instruction sets pcsrc=0.
REQ-025 Unsupported combinations -> aluresult2=0, pcsrc=0.
REQ-026 Arithmetic SHALL be modulo 2^32; there are no overflow outputs.
REQ-027 aluresult1 SHALL be updated together with aluresult2 at the same EX edge.
REQ-028 Outputs SHALL hold their values in every estado other than the one that updates them.
REQ-029 Latency: each update is visible one edge after the corresponding phase is presented.

Reset
REQ-030 rst low SHALL immediately clear instrucao, all decoded fields, immediate, negativo, tipo, aluresult1, aluresult2 and pcsrc to 0, even mid-operation; tipo clears to 0.
REQ-031 Reset SHALL NOT alter imem contents.
REQ-032 While rst is low, imem writes and phase updates SHALL be ignored.

Verification
REQ-033 imem[0]=0x00500093, PC=0, IF/ID/EX with A=0 -> opcode=0x13, rd=1, immediate=5, tipo=2, aluresult2=5, aluresult1=0.
REQ-034 imem[1]=0x402081B3, PC=4, A=10, B=3 -> tipo=0, rd=3, aluresult2=7, pcsrc=0.
REQ-035 imem[2]=0xFE208CE3, A=B=9 -> immediate=0xFFFFFFF8, negativo=1, aluresult1=1, pcsrc=1; with A=9, B=8 -> pcsrc=0.
REQ-036 srl 0x007352B3, A=0x80000000, B=4 -> aluresult2=0x08000000.
REQ-037 PC=0x100 (index 64 >= IMEM_DEPTH) -> instrucao=0; same-edge imem write plus IF fetch of the same word -> fetched value is the old data.
REQ-038 rst low during EX -> all outputs 0 at once; after release, re-fetch of PC=0 returns 0x00500093.

Source files
------------

// File: rtl/riscv_fetch_decode_execute.sv
// riscv_fetch_decode_execute
//   Phase-driven fetch / decode / execute slice of a small RV32I datapath.
//   The surrounding controller presents a phase code on estado each cycle;
//   the matching stage updates its registers on that rising edge. All other
//   stages hold their outputs. The supported subset is add, sub, xor, srl,
//   addi, lw, sw and beq.
//
// Phase protocol: estado acts as a one-cycle strobe per stage. IF=4'b0000
//   loads instrucao, ID=4'b0001 loads the decoded fields, EX=4'b0010 loads the
//   ALU outputs. Any other code holds everything. Results are visible one
//   edge after the phase is presented. There is no back-pressure.
//
// Ports
//   clk                     sole clock, rising edge
//   rst                     asynchronous reset, active low
//   estado[3:0]             phase code (IF / ID / EX / hold)
//   PC[31:0]                byte address of the instruction to fetch
//   readdata1R/readdata2R   rs1 / rs2 operand values used during EX
//   imem_we/addr/wdata      synchronous instruction-memory write port
//   instrucao               fetched instruction
//   opcode rd rs1 rs2 funct3 funct7   decoded fields (latched at ID)
//   immediate, negativo     sign-extended immediate and its sign bit
//   tipo                    0=R 1=load 2=I-arith 3=store 4=branch 7=unsupported
//   aluresult2              ALU result; aluresult1 = (aluresult2 == 0)
//   pcsrc                   branch taken (beq with equal operands)
module riscv_fetch_decode_execute #(
  parameter int IMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  estado,
  input  logic [31:0] PC,
  input  logic [31:0] readdata1R,
  input  logic [31:0] readdata2R,
  input  logic        imem_we,
  input  logic [4:0]  imem_addr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] instrucao,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] immediate,
  output logic        negativo,
  output logic [2:0]  tipo,
  output logic [31:0] aluresult2,
  output logic        aluresult1,
  output logic        pcsrc
);

  localparam int IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  localparam logic [3:0] PH_IF = 4'b0000;
  localparam logic [3:0] PH_ID = 4'b0001;
  localparam logic [3:0] PH_EX = 4'b0010;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] T_R      = 3'd0;
  localparam logic [2:0] T_LOAD   = 3'd1;
  localparam logic [2:0] T_IARITH = 3'd2;
  localparam logic [2:0] T_STORE  = 3'd3;
  localparam logic [2:0] T_BRANCH = 3'd4;
  localparam logic [2:0] T_UNSUP  = 3'd7;

  // ---------------------------------------------------------------------
  // Instruction memory. Not reset, so its contents survive rst; writes
  // are simply gated off while rst is low.
  // ---------------------------------------------------------------------
  logic [31:0]      imem [IMEM_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_in_range;
  logic             unused_pc_low;

  assign wr_idx         = IDX_W'(imem_addr);
  assign wr_in_range    = {27'd0, imem_addr} < 32'(IMEM_DEPTH);
  assign fetch_idx      = PC[IDX_W+1:2];
  assign fetch_in_range = PC[31:2] < 30'(IMEM_DEPTH);
  assign unused_pc_low  = &{1'b0, PC[1:0]};

  always_ff @(posedge clk) begin
    if (rst && imem_we && wr_in_range) begin
      imem[wr_idx] <= imem_wdata;
    end
  end

  // Fetch reads the array in the same edge as any write, so a same-word
  // write/fetch collision returns the previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instrucao <= '0;
    end else if (estado == PH_IF) begin
      instrucao <= fetch_in_range ? imem[fetch_idx] : 32'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Decode: class and immediate are derived from instrucao and latched
  // alongside the raw fields at ID.
  // ---------------------------------------------------------------------
  logic [2:0]  dec_tipo;
  logic [31:0] dec_imm;

  always_comb begin
    dec_tipo = T_UNSUP;
    dec_imm  = '0;
    case (instrucao[6:0])
      OP_R: begin
        dec_tipo = T_R;
      end
      OP_LOAD: begin
        dec_tipo = T_LOAD;
        dec_imm  = {{20{instrucao[31]}}, instrucao[31:20]};
      end
      OP_IARITH: begin
        dec_tipo = T_IARITH;
        dec_imm  = {{20{instrucao[31]}}, instrucao[31:20]};
      end
      OP_STORE: begin
        dec_tipo = T_STORE;
        dec_imm  = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
      end
      OP_BRANCH: begin
        dec_tipo = T_BRANCH;
        dec_imm  = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                    instrucao[30:25], instrucao[11:8], 1'b0};
      end
      default: begin
        dec_tipo = T_UNSUP;
        dec_imm  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode    <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      funct3    <= '0;
      funct7    <= '0;
      immediate <= '0;
      negativo  <= 1'b0;
      tipo      <= '0;
    end else if (estado == PH_ID) begin
      opcode    <= instrucao[6:0];
      rd        <= instrucao[11:7];
      funct3    <= instrucao[14:12];
      rs1       <= instrucao[19:15];
      rs2       <= instrucao[24:20];
      funct7    <= instrucao[31:25];
      immediate <= dec_imm;
      negativo  <= dec_imm[31];
      tipo      <= dec_tipo;
    end
  end

  // ---------------------------------------------------------------------
  // Execute: operates only on fields latched at ID. Anything outside the
  // supported subset yields a zero result and no branch.
  // ---------------------------------------------------------------------
  logic [31:0] ex_result;
  logic        ex_taken;

  always_comb begin
    ex_result = '0;
    ex_taken  = 1'b0;
    case (tipo)
      T_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0100000)      ex_result = readdata1R - readdata2R;
            else if (funct7 == 7'b0000000) ex_result = readdata1R + readdata2R;
          end
          3'b100: if (funct7 == 7'b0000000) ex_result = readdata1R ^ readdata2R;
          3'b101: if (funct7 == 7'b0000000) ex_result = readdata1R >> readdata2R[4:0];
          default: ex_result = '0;
        endcase
      end
      T_IARITH: if (funct3 == 3'b000) ex_result = readdata1R + immediate;
      T_LOAD:   if (funct3 == 3'b010) ex_result = readdata1R + immediate;
      T_STORE:  if (funct3 == 3'b010) ex_result = readdata1R + immediate;
      T_BRANCH: begin
        if (funct3 == 3'b000) begin
          ex_result = readdata1R - readdata2R;
          ex_taken  = (readdata1R == readdata2R);
        end
      end
      default: begin
        ex_result = '0;
        ex_taken  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluresult2 <= '0;
      aluresult1 <= 1'b0;
      pcsrc      <= 1'b0;
    end else if (estado == PH_EX) begin
      aluresult2 <= ex_result;
      aluresult1 <= (ex_result == 32'd0);
      pcsrc      <= ex_taken;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_decode_execute.sv
// tb_riscv_fetch_decode_execute
//   Directed vectors with hand-computed expectations for the phase-driven
//   fetch / decode / execute slice.
module tb_riscv_fetch_decode_execute;

  localparam logic [3:0] PH_IF   = 4'b0000;
  localparam logic [3:0] PH_ID   = 4'b0001;
  localparam logic [3:0] PH_EX   = 4'b0010;
  localparam logic [3:0] PH_HOLD = 4'b1111;

  logic        clk;
  logic        rst;
  logic [3:0]  estado;
  logic [31:0] PC;
  logic [31:0] readdata1R;
  logic [31:0] readdata2R;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] instrucao;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immediate;
  logic        negativo;
  logic [2:0]  tipo;
  logic [31:0] aluresult2;
  logic        aluresult1;
  logic        pcsrc;

  int n_vec;
  int n_err;

  riscv_fetch_decode_execute #(.IMEM_DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .estado     (estado),
    .PC         (PC),
    .readdata1R (readdata1R),
    .readdata2R (readdata2R),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .instrucao  (instrucao),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .immediate  (immediate),
    .negativo   (negativo),
    .tipo       (tipo),
    .aluresult2 (aluresult2),
    .aluresult1 (aluresult1),
    .pcsrc      (pcsrc)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present a phase for exactly one rising edge, then return to hold.
  task automatic step(input logic [3:0] ph);
    estado = ph;
    @(posedge clk);
    #1;
    estado = PH_HOLD;
  endtask

  task automatic fetch(input logic [31:0] pc);
    PC = pc;
    step(PH_IF);
  endtask

  task automatic exec(input logic [31:0] a, input logic [31:0] b);
    readdata1R = a;
    readdata2R = b;
    step(PH_EX);
  endtask

  task automatic write_imem(input logic [4:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_addr  = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  logic [31:0] prog [9];

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    estado     = PH_HOLD;
    PC         = '0;
    readdata1R = '0;
    readdata2R = '0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;

    prog[0] = 32'h00500093; // addi x1, x0, 5
    prog[1] = 32'h402081B3; // sub  x3, x1, x2
    prog[2] = 32'hFE208CE3; // beq  x1, x2, -8
    prog[3] = 32'h007352B3; // srl  x5, x6, x7
    prog[4] = 32'h0080A283; // lw   x5, 8(x1)
    prog[5] = 32'hFE20AE23; // sw   x2, -4(x1)
    prog[6] = 32'h007342B3; // xor  x5, x6, x7
    prog[7] = 32'h002081B3; // add  x3, x1, x2
    prog[8] = 32'h123452B7; // lui  (unsupported)

    // ---- reset state ----
    #2;
    check_eq("rst_instrucao", instrucao, 32'h0);
    check_eq("rst_opcode", 32'(opcode), 32'h0);
    check_eq("rst_immediate", immediate, 32'h0);
    check_eq("rst_tipo", 32'(tipo), 32'h0);
    check_eq("rst_alu", aluresult2, 32'h0);
    check_eq("rst_zero", 32'(aluresult1), 32'h0);
    check_eq("rst_pcsrc", 32'(pcsrc), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) write_imem(5'(i), prog[i]);

    // ---- addi x1, x0, 5 ----
    fetch(32'd0);
    check_eq("addi_instr", instrucao, 32'h00500093);
    step(PH_ID);
    check_eq("addi_opcode", 32'(opcode), 32'h13);
    check_eq("addi_rd", 32'(rd), 32'd1);
    check_eq("addi_rs1", 32'(rs1), 32'd0);
    check_eq("addi_imm", immediate, 32'd5);
    check_eq("addi_neg", 32'(negativo), 32'd0);
    check_eq("addi_tipo", 32'(tipo), 32'd2);
    exec(32'd0, 32'd0);
    check_eq("addi_alu", aluresult2, 32'd5);
    check_eq("addi_zero", 32'(aluresult1), 32'd0);
    check_eq("addi_pcsrc", 32'(pcsrc), 32'd0);
    // outputs hold on a non-phase code
    readdata1R = 32'd100;
    step(4'b0011);
    check_eq("hold_alu", aluresult2, 32'd5);
    check_eq("hold_instr", instrucao, 32'h00500093);

    // ---- sub x3, x1, x2 ----
    fetch(32'd4);
    step(PH_ID);
    check_eq("sub_tipo", 32'(tipo), 32'd0);
    check_eq("sub_rd", 32'(rd), 32'd3);
    check_eq("sub_rs2", 32'(rs2), 32'd2);
    check_eq("sub_funct7", 32'(funct7), 32'h20);
    check_eq("sub_imm", immediate, 32'd0);
    exec(32'd10, 32'd3);
    check_eq("sub_alu", aluresult2, 32'd7);
    check_eq("sub_pcsrc", 32'(pcsrc), 32'd0);

    // ---- beq x1, x2, -8 ----
    fetch(32'd8);
    step(PH_ID);
    check_eq("beq_imm", immediate, 32'hFFFFFFF8);
    check_eq("beq_neg", 32'(negativo), 32'd1);
    check_eq("beq_tipo", 32'(tipo), 32'd4);
    exec(32'd9, 32'd9);
    check_eq("beq_eq_alu", aluresult2, 32'd0);
    check_eq("beq_eq_zero", 32'(aluresult1), 32'd1);
    check_eq("beq_eq_pcsrc", 32'(pcsrc), 32'd1);
    exec(32'd9, 32'd8);
    check_eq("beq_ne_alu", aluresult2, 32'd1);
    check_eq("beq_ne_zero", 32'(aluresult1), 32'd0);
    check_eq("beq_ne_pcsrc", 32'(pcsrc), 32'd0);

    // ---- srl x5, x6, x7 ----
    fetch(32'd12);
    step(PH_ID);
    check_eq("srl_funct3", 32'(funct3), 32'd5);
    exec(32'h80000000, 32'd4);
    check_eq("srl_alu", aluresult2, 32'h08000000);
    exec(32'hF0000000, 32'h00000021); // only B[4:0]=1 counts
    check_eq("srl_mask_alu", aluresult2, 32'h78000000);

    // ---- lw x5, 8(x1) ----
    fetch(32'd16);
    step(PH_ID);
    check_eq("lw_tipo", 32'(tipo), 32'd1);
    check_eq("lw_imm", immediate, 32'd8);
    exec(32'h100, 32'h0);
    check_eq("lw_alu", aluresult2, 32'h108);

    // ---- sw x2, -4(x1) ----
    fetch(32'd20);
    step(PH_ID);
    check_eq("sw_tipo", 32'(tipo), 32'd3);
    check_eq("sw_imm", immediate, 32'hFFFFFFFC);
    check_eq("sw_neg", 32'(negativo), 32'd1);
    exec(32'h100, 32'h55);
    check_eq("sw_alu", aluresult2, 32'hFC);

    // ---- xor x5, x6, x7 ----
    fetch(32'd24);
    step(PH_ID);
    exec(32'hF0F0F0F0, 32'hFF00FF00);
    check_eq("xor_alu", aluresult2, 32'h0FF00FF0);

    // ---- add x3, x1, x2 (wraps modulo 2^32) ----
    fetch(32'd28);
    step(PH_ID);
    exec(32'hFFFFFFFF, 32'd1);
    check_eq("add_wrap_alu", aluresult2, 32'd0);
    check_eq("add_wrap_zero", 32'(aluresult1), 32'd1);
    exec(32'd7, 32'd5);
    check_eq("add_alu", aluresult2, 32'd12);

    // ---- unsupported opcode ----
    fetch(32'd32);
    step(PH_ID);
    check_eq("unsup_tipo", 32'(tipo), 32'd7);
    check_eq("unsup_opcode", 32'(opcode), 32'h37);
    check_eq("unsup_imm", immediate, 32'd0);
    exec(32'd5, 32'd5);
    check_eq("unsup_alu", aluresult2, 32'd0);
    check_eq("unsup_pcsrc", 32'(pcsrc), 32'd0);

    // ---- fetch beyond memory ----
    fetch(32'h100);
    check_eq("oob_instr", instrucao, 32'h0);

    // ---- same-edge write and fetch of word 0 ----
    imem_we    = 1'b1;
    imem_addr  = 5'd0;
    imem_wdata = 32'hDEADBEEF;
    fetch(32'd0);
    imem_we = 1'b0;
    check_eq("rw_old_data", instrucao, 32'h00500093);
    fetch(32'd0);
    check_eq("rw_new_data", instrucao, 32'hDEADBEEF);
    write_imem(5'd0, 32'h00500093);

    // ---- asynchronous reset in the middle of EX ----
    fetch(32'd8);
    step(PH_ID);
    exec(32'd4, 32'd4);
    estado     = PH_EX;
    readdata1R = 32'd9;
    readdata2R = 32'd2;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_instr", instrucao, 32'h0);
    check_eq("arst_imm", immediate, 32'h0);
    check_eq("arst_neg", 32'(negativo), 32'h0);
    check_eq("arst_tipo", 32'(tipo), 32'h0);
    check_eq("arst_alu", aluresult2, 32'h0);
    check_eq("arst_zero", 32'(aluresult1), 32'h0);
    check_eq("arst_pcsrc", 32'(pcsrc), 32'h0);
    // writes and phases are ignored while held in reset
    imem_we    = 1'b1;
    imem_addr  = 5'd0;
    imem_wdata = 32'h11111111;
    PC         = 32'd0;
    step(PH_IF);
    imem_we = 1'b0;
    check_eq("inrst_instr", instrucao, 32'h0);
    rst = 1'b1;
    fetch(32'd0);
    check_eq("post_rst_instr", instrucao, 32'h00500093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
